// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer: each input word is routed by S into one
// of four single-entry output slots, each with its own valid/ready handshake and delivered-word counter.
module demux_1x4_stream #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       I,
    input  logic [1:0]         S,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*W-1:0]     Y,
    output logic [3:0]         Y_valid,
    input  logic [3:0]         Y_ready,
    output logic [4*CNT_W-1:0] cnt
);

    logic [W-1:0]     data_reg  [4];
    logic [CNT_W-1:0] cnt_reg   [4];
    logic [3:0]       valid_reg;
    logic [3:0]       xfer;
    logic [3:0]       load;
    logic             accept;

    // Only the selected slot gates acceptance; a full slot frees up in the same
    // cycle its consumer takes the word, giving back-to-back pass-through.
    assign in_ready = ~rst & (~valid_reg[S] | Y_ready[S]);
    assign accept   = in_valid & in_ready;
    assign Y_valid  = valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign xfer[gi] = valid_reg[gi] & Y_ready[gi];
            assign load[gi] = accept & (S == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi]  <= '0;
                    valid_reg[gi] <= 1'b0;
                    cnt_reg[gi]   <= '0;
                end else begin
                    if (load[gi]) begin
                        data_reg[gi]  <= I;
                        valid_reg[gi] <= 1'b1;
                    end else if (xfer[gi]) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (xfer[gi]) begin
                        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                    end
                end
            end

            assign Y[gi*W +: W]         = data_reg[gi];
            assign cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed testbench for demux_1x4_stream: reset, routing, pass-through,
// stall isolation, counter wrap and mid-operation reset.
module tb_demux_1x4_stream;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       I;
    logic [1:0]         S;
    logic               in_valid;
    logic               in_ready;
    logic [4*W-1:0]     Y;
    logic [3:0]         Y_valid;
    logic [3:0]         Y_ready;
    logic [4*CNT_W-1:0] cnt;

    int errors = 0;
    int checks = 0;

    demux_1x4_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .I        (I),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Y        (Y),
        .Y_valid  (Y_valid),
        .Y_ready  (Y_ready),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled just after the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] chan(input int k);
        return Y[k*W +: W];
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        S        = 2'd0;
        I        = 8'h11;
        Y_ready  = 4'b0000;

        // 1. reset held for two cycles with in_valid asserted
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_y_valid",  64'(Y_valid),  64'd0);
            check("rst_cnt",      64'(cnt),      64'd0);
        end
        check("rst_y", 64'(Y), 64'd0);
        rst = 1'b0;

        // 2. routing to all four channels with consumers stalled
        for (int k = 0; k < 4; k++) begin
            S = 2'(k);
            I = 8'hA0 + 8'(k);
            #1;
            check("route_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        S = 2'd2;
        I = 8'hFF;
        #1;
        check("route_y_valid",  64'(Y_valid),  64'hF);
        check("route_y",        64'(Y),        64'hA3A2A1A0);
        check("route_blocked",  64'(in_ready), 64'd0);
        step();
        check("route_y_held", 64'(Y), 64'hA3A2A1A0);
        in_valid = 1'b0;

        // clear slots before the pass-through run
        rst = 1'b1;
        step();
        rst = 1'b0;

        // 3. pass-through on channel 1, 16 back-to-back words
        S       = 2'd1;
        Y_ready = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            I        = 8'(i);
            #1;
            check("pt_in_ready", 64'(in_ready), 64'd1);
            if (i > 0) begin
                check("pt_valid", 64'(Y_valid[1]), 64'd1);
                check("pt_data",  64'(chan(1)),    64'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check("pt_last_data", 64'(chan(1)), 64'd15);
        step();
        check("pt_cnt",     64'(cnt),     64'h00001000);
        check("pt_drained", 64'(Y_valid), 64'd0);

        // 4. stall isolation: channel 0 full and stalled, channel 3 still accepts
        Y_ready  = 4'b0000;
        in_valid = 1'b1;
        S        = 2'd0;
        I        = 8'h3C;
        step();
        in_valid = 1'b0;
        #1;
        check("iso_ch0_blocks", 64'(in_ready), 64'd0);
        S = 2'd3;
        I = 8'h5C;
        in_valid = 1'b1;
        #1;
        check("iso_ch3_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        S = 2'd1;
        I = 8'hEE;
        #1;
        check("iso_y_valid", 64'(Y_valid), 64'b1001);
        check("iso_ch0",     64'(chan(0)),  64'h3C);
        check("iso_ch3",     64'(chan(3)),  64'h5C);
        step();
        check("idle_no_change", 64'(Y_valid), 64'b1001);
        check("idle_ch1_held",  64'(chan(1)), 64'd15);

        // 5. 256 handshakes on channel 2 wrap its counter; others untouched
        Y_ready = 4'b0100;
        S       = 2'd2;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            I        = 8'(i);
            step();
        end
        in_valid = 1'b0;
        check("wrap_cnt_255", 64'(cnt), 64'h00FF1000);
        check("wrap_last",    64'(chan(2)), 64'hFF);
        step();
        check("wrap_cnt_0",  64'(cnt),     64'h00001000);
        check("wrap_valid",  64'(Y_valid), 64'b1001);

        // 6. reset with channels 0 and 3 full and their consumers ready
        Y_ready = 4'b1001;
        rst     = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        step();
        rst     = 1'b0;
        Y_ready = 4'b0000;
        #1;
        check("mid_rst_valid", 64'(Y_valid), 64'd0);
        check("mid_rst_cnt",   64'(cnt),     64'd0);
        check("mid_rst_y",     64'(Y),       64'd0);
        S        = 2'd3;
        I        = 8'h77;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_valid", 64'(Y_valid), 64'b1000);
        check("post_rst_ch3",   64'(chan(3)), 64'h77);
        Y_ready = 4'b1000;
        step();
        check("post_rst_cnt",   64'(cnt),     64'h01000000);
        check("post_rst_empty", 64'(Y_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
